// File: rtl/cxu_fxp_pkg.sv
// Shared opcode codes and the saturation helper for the fixed-point MAC CXU.
package cxu_fxp_pkg;

  localparam logic [2:0] FN_MUL   = 3'd0;
  localparam logic [2:0] FN_MULSH = 3'd1;
  localparam logic [2:0] FN_MAC   = 3'd2;
  localparam logic [2:0] FN_CLR   = 3'd3;
  localparam logic [2:0] FN_RD    = 3'd4;
  localparam logic [2:0] FN_LD    = 3'd5;

  localparam int SAT_W = 64;

  // Clamp a signed value to the signed w-bit range; callers keep the low w bits.
  function automatic logic [SAT_W-1:0] sat_clamp(input logic signed [SAT_W:0] v,
                                                 input int w, input logic en);
    logic signed [SAT_W:0] hi, lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    sat_clamp = v[SAT_W-1:0];
    if (en && (v > hi))      sat_clamp = hi[SAT_W-1:0];
    else if (en && (v < lo)) sat_clamp = lo[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/cxu_fxp_mul_pipe.sv
// Signed XLEN x XLEN multiplier with STAGES register stages; opcode, state_id and A ride alongside.
module cxu_fxp_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_vld,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_sid,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  output logic              out_vld,
  output logic [2:0]        out_op,
  output logic [2:0]        out_sid,
  output logic [XLEN-1:0]   out_a,
  output logic [2*XLEN-1:0] out_p
);

  typedef struct packed {
    logic [2:0]        op;
    logic [2:0]        sid;
    logic [XLEN-1:0]   a;
    logic [2*XLEN-1:0] p;
  } sb_t;

  sb_t sb_in, sb_out;

  always_comb begin
    sb_in     = '0;
    sb_in.op  = in_op;
    sb_in.sid = in_sid;
    sb_in.a   = in_a;
    sb_in.p   = $signed({{XLEN{in_a[XLEN-1]}}, in_a}) * $signed({{XLEN{in_b[XLEN-1]}}, in_b});
  end

  generate
    if (STAGES == 0) begin : g_comb
      assign out_vld = in_vld;
      assign sb_out  = sb_in;
    end else begin : g_reg
      logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
      sb_t  [STAGES-1:0] sb_q, sb_d;

      always_comb begin
        vld_pipe_d = vld_pipe_q;
        sb_d       = sb_q;
        if (en) begin
          vld_pipe_d[0] = in_vld;
          sb_d[0]       = sb_in;
          for (int i = 1; i < STAGES; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            sb_d[i]       = sb_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_pipe_q <= '0;
          sb_q       <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          sb_q       <= sb_d;
        end
      end

      assign out_vld = vld_pipe_q[STAGES-1];
      assign sb_out  = sb_q[STAGES-1];
    end
  endgenerate

  assign out_op  = sb_out.op;
  assign out_sid = sb_out.sid;
  assign out_a   = sb_out.a;
  assign out_p   = sb_out.p;

endmodule

// File: rtl/cxu_fxp_mac.sv
// Pipelined fixed-point multiply/accumulate CXU with internal saturating accumulators.
module cxu_fxp_mac
  import cxu_fxp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FRAC_BITS   = 10,
  parameter int PIPE_STAGES = 2,
  parameter int NUM_STATES  = 8,
  parameter int SATURATE    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_payload_function_id,
  input  logic [XLEN-1:0] cmd_payload_inputs_0,
  input  logic [XLEN-1:0] cmd_payload_inputs_1,
  input  logic [2:0]      cmd_payload_state_id,
  input  logic [3:0]      cmd_payload_cxu_id,
  input  logic            cmd_payload_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_payload_outputs_0,
  output logic            rsp_payload_ready,
  input  logic [2047:0]   state_read,
  output logic [2047:0]   state_write,
  output logic            state_write_en
);

  logic                    stall;
  logic                    f_vld;
  logic [2:0]              f_op, f_sid;
  logic [XLEN-1:0]         f_a;
  logic [2*XLEN-1:0]       f_p;

  logic                    rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]         rsp_out_q, rsp_out_d;
  logic [NUM_STATES-1:0][XLEN-1:0] acc_q, acc_d;

  logic [XLEN-1:0]         shifted, acc_rd, acc_new, mac_res, res;
  logic [XLEN:0]           sum;
  logic                    acc_wr;

  assign stall     = rsp_valid_q & ~rsp_ready;
  assign cmd_ready = ~stall;

  cxu_fxp_mul_pipe #(.XLEN(XLEN), .STAGES(PIPE_STAGES - 1)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .en      (~stall),
    .in_vld  (cmd_valid & cmd_ready),
    .in_op   (cmd_payload_function_id),
    .in_sid  (cmd_payload_state_id),
    .in_a    (cmd_payload_inputs_0),
    .in_b    (cmd_payload_inputs_1),
    .out_vld (f_vld),
    .out_op  (f_op),
    .out_sid (f_sid),
    .out_a   (f_a),
    .out_p   (f_p)
  );

  // Final stage: accumulator read-modify-write happens only here, so consecutive
  // ops on the same state_id see each other's results without forwarding.
  always_comb begin
    shifted = f_p[FRAC_BITS+XLEN-1:FRAC_BITS];
    acc_rd  = '0;
    for (int i = 0; i < NUM_STATES; i++)
      if (f_sid == 3'(i)) acc_rd = acc_q[i];
    sum     = {acc_rd[XLEN-1], acc_rd} + {shifted[XLEN-1], shifted};
    mac_res = XLEN'(sat_clamp((SAT_W+1)'($signed(sum)), XLEN, SATURATE != 0));

    res     = '0;
    acc_new = acc_rd;
    acc_wr  = 1'b0;
    case (f_op)
      FN_MUL:   res = f_p[XLEN-1:0];
      FN_MULSH: res = shifted;
      FN_MAC:   begin res = mac_res; acc_new = mac_res; acc_wr = 1'b1; end
      FN_CLR:   begin res = acc_rd;  acc_new = '0;      acc_wr = 1'b1; end
      FN_RD:    res = acc_rd;
      FN_LD:    begin
        res     = acc_rd;
        acc_new = XLEN'(sat_clamp((SAT_W+1)'($signed(f_a)), XLEN, SATURATE != 0));
        acc_wr  = 1'b1;
      end
      default:  res = '0;
    endcase

    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    acc_d       = acc_q;
    if (!stall) begin
      rsp_valid_d = f_vld;
      if (f_vld) begin
        rsp_out_d = res;
        if (acc_wr)
          for (int i = 0; i < NUM_STATES; i++)
            if (f_sid == 3'(i)) acc_d[i] = acc_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      acc_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      acc_q       <= acc_d;
    end
  end

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_out_q;
  assign rsp_payload_ready     = 1'b1;
  assign state_write           = '0;
  assign state_write_en        = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{state_read, cmd_payload_cxu_id, cmd_payload_ready, f_p};

endmodule

// File: tb/tb_cxu_fxp_mac.sv
// Self-checking bench for cxu_fxp_mac: vector table plus stall and reset sequences, scoreboarded.
module tb_cxu_fxp_mac;

  localparam int P = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    fn;
  logic [31:0]   in0, in1;
  logic [2:0]    sid;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_out;
  logic          rsp_pr;
  logic [2047:0] st_rd;
  logic [2047:0] st_wr;
  logic          st_we;

  int            errors = 0;
  int            checks = 0;
  int            rsp_cnt = 0;
  logic [31:0]   cur_exp;
  logic [31:0]   exp_q[$];

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sid;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  cxu_fxp_mac #(.XLEN(32), .FRAC_BITS(10), .PIPE_STAGES(P), .NUM_STATES(8), .SATURATE(1)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fn),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .cmd_payload_state_id    (sid),
    .cmd_payload_cxu_id      (4'd0),
    .cmd_payload_ready       (1'b0),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_out),
    .rsp_payload_ready       (rsp_pr),
    .state_read              (st_rd),
    .state_write             (st_wr),
    .state_write_en          (st_we)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (check %0d): got %h expected %h", nm, checks, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) exp_q.push_back(cur_exp);
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h with no response outstanding", rsp_out);
      end else begin
        chk("rsp", rsp_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] s, input logic [31:0] e);
    bit acc;
    int n;
    cmd_valid = 1'b1; fn = f; in0 = a; in1 = b; sid = s; cur_exp = e;
    acc = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] s, input logic [31:0] e);
    vec_t v;
    v.fn = f; v.a = a; v.b = b; v.sid = s; v.exp = e;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, base;
    reset = 1'b1; cmd_valid = 1'b0; fn = '0; in0 = '0; in1 = '0; sid = '0;
    rsp_ready = 1'b1; st_rd = '0; cur_exp = '0;

    tbl.push_back(mk(3'd1, 32'hFFFFFFFD, 32'h00000100, 3'd0, 32'hFFFFFFFF));
    tbl.push_back(mk(3'd0, 32'h00010000, 32'h00010000, 3'd0, 32'h00000000));
    tbl.push_back(mk(3'd1, 32'h00010000, 32'h00010000, 3'd0, 32'h00400000));
    tbl.push_back(mk(3'd5, 32'h00000000, 32'h0,        3'd2, 32'h00000000));
    tbl.push_back(mk(3'd2, 32'h00000400, 32'h00000400, 3'd2, 32'h00000400));
    tbl.push_back(mk(3'd2, 32'h00000400, 32'h00000400, 3'd2, 32'h00000800));
    tbl.push_back(mk(3'd2, 32'h00000400, 32'h00000400, 3'd2, 32'h00000C00));
    tbl.push_back(mk(3'd4, 32'h0,        32'h0,        3'd2, 32'h00000C00));
    tbl.push_back(mk(3'd4, 32'h0,        32'h0,        3'd3, 32'h00000000));
    tbl.push_back(mk(3'd5, 32'h7FFFFF00, 32'h0,        3'd1, 32'h00000000));
    tbl.push_back(mk(3'd2, 32'h00100000, 32'h00100000, 3'd1, 32'h7FFFFFFF));
    tbl.push_back(mk(3'd5, 32'h80000100, 32'h0,        3'd1, 32'h7FFFFFFF));
    tbl.push_back(mk(3'd2, 32'hFFF00000, 32'h00100000, 3'd1, 32'h80000000));
    tbl.push_back(mk(3'd5, 32'h00001234, 32'h0,        3'd4, 32'h00000000));
    tbl.push_back(mk(3'd3, 32'h0,        32'h0,        3'd4, 32'h00001234));
    tbl.push_back(mk(3'd4, 32'h0,        32'h0,        3'd4, 32'h00000000));
    tbl.push_back(mk(3'd7, 32'h00000005, 32'h00000006, 3'd2, 32'h00000000));
    tbl.push_back(mk(3'd6, 32'h00000005, 32'h00000006, 3'd1, 32'h00000000));
    tbl.push_back(mk(3'd4, 32'h0,        32'h0,        3'd2, 32'h00000C00));
    tbl.push_back(mk(3'd4, 32'h0,        32'h0,        3'd1, 32'h80000000));
    tbl.push_back(mk(3'd5, 32'h00000055, 32'h0,        3'd6, 32'h00000000));
    tbl.push_back(mk(3'd5, 32'h00000000, 32'h0,        3'd5, 32'h00000000));

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_out", rsp_out, 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("tie_rsp_payload_ready", 32'(rsp_pr), 32'd1);
    chk("tie_state_write_en", 32'(st_we), 32'd0);
    @(posedge clk); #2;

    // Isolated MUL / MULSH with latency measurement
    send(3'd0, 32'd3, 32'hFFFFFFFC, 3'd0, 32'hFFFFFFF4);
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin @(posedge clk); k++; @(negedge clk); end
    chk("latency_mul", 32'(k), 32'(P - 1));
    @(posedge clk); #2;
    drain();
    send(3'd1, 32'h00000800, 32'h00000C00, 3'd0, 32'h00001800);
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin @(posedge clk); k++; @(negedge clk); end
    chk("latency_mulsh", 32'(k), 32'(P - 1));
    @(posedge clk); #2;
    drain();

    // Back-to-back table vectors
    foreach (tbl[i]) send(tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].sid, tbl[i].exp);
    drain();

    // Streamed MACs on state 5 with backpressure
    base = rsp_cnt;
    fork
      begin
        for (int j = 1; j <= 10; j++)
          send(3'd2, 32'h00000400, 32'h00000400, 3'd5, 32'(j * 32'h400));
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
          chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
      end
    join
    drain();
    chk("stream_rsp_count", 32'(rsp_cnt - base), 32'd10);

    // Reset with two commands in flight
    rsp_ready = 1'b0;
    send(3'd2, 32'h00000400, 32'h00000400, 3'd0, 32'h00000400);
    send(3'd0, 32'd7, 32'd9, 3'd0, 32'd63);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #2;
    send(3'd4, 32'h0, 32'h0, 3'd6, 32'h0);
    send(3'd4, 32'h0, 32'h0, 3'd5, 32'h0);
    send(3'd4, 32'h0, 32'h0, 3'd2, 32'h0);
    send(3'd4, 32'h0, 32'h0, 3'd0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
